// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard port.
// Status/control bit positions match the CPU-visible register word.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PS2_DATA_BITS = 8;

    localparam int STAT_VALID = 8;
    localparam int STAT_OVF   = 9;
    localparam int STAT_PERR  = 10;

    localparam int CTRL_FLUSH = 8;

endpackage

// File: rtl/ps2_kbd_ports_if.sv
// CPU I/O-bus slave port bundle for the PS/2 keyboard peripheral.
// Master is the CPU side, slave is the peripheral.
interface ps2_kbd_ports_if;

    logic        cs;
    logic        data_m_access;
    logic        data_m_wr_en;
    logic [1:0]  data_m_bytesel;
    logic [15:0] data_m_data_in;
    logic [15:0] data_m_data_out;
    logic        data_m_ack;

    modport master (
        output cs,
        output data_m_access,
        output data_m_wr_en,
        output data_m_bytesel,
        output data_m_data_in,
        input  data_m_data_out,
        input  data_m_ack
    );

    modport slave (
        input  cs,
        input  data_m_access,
        input  data_m_wr_en,
        input  data_m_bytesel,
        input  data_m_data_in,
        output data_m_data_out,
        output data_m_ack
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: sync, glitch filter, frame FSM.
// Optional idle-clock abort built when PS2_RX_TIMEOUT_EN is defined.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int filter_len = 4
`ifdef PS2_RX_TIMEOUT_EN
    ,
    parameter int timeout_cycles = 50000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       perr
);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [filter_len-1:0] clk_hist;
    logic [filter_len-1:0] dat_hist;
    logic                  filt_clk;
    logic                  filt_clk_d;
    logic                  filt_dat;
    logic                  strobe;
    logic                  tmo;

    rx_state_e state, state_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [PS2_DATA_BITS-1:0] shreg, shreg_nx;
    logic par, par_nx;
    logic push_nx, perr_nx;

    // Idle line level is high, so filters start settled at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync   <= '1;
            dat_sync   <= '1;
            clk_hist   <= '1;
            dat_hist   <= '1;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            filt_dat   <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_dat};
            clk_hist   <= {clk_hist[filter_len-2:0], clk_sync[1]};
            dat_hist   <= {dat_hist[filter_len-2:0], dat_sync[1]};
            filt_clk_d <= filt_clk;
            if (&clk_hist)
                filt_clk <= 1'b1;
            else if (~|clk_hist)
                filt_clk <= 1'b0;
            if (&dat_hist)
                filt_dat <= 1'b1;
            else if (~|dat_hist)
                filt_dat <= 1'b0;
        end
    end

    assign strobe = filt_clk_d & ~filt_clk;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(timeout_cycles + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state == IDLE || strobe)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign tmo = (state != IDLE) && !strobe &&
                 (tmo_cnt == TW'(timeout_cycles - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            perr       <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            shreg      <= shreg_nx;
            par        <= par_nx;
            byte_valid <= push_nx;
            perr       <= perr_nx;
            if (push_nx)
                rx_byte <= shreg;
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        par_nx     = par;
        push_nx    = 1'b0;
        perr_nx    = 1'b0;
        if (tmo) begin
            state_nx = IDLE;
            perr_nx  = 1'b1;
        end else if (strobe) begin
            unique case (state)
                IDLE: begin
                    if (!filt_dat) begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end
                end
                DATA: begin
                    shreg_nx   = {filt_dat, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nx = PARITY;
                end
                PARITY: begin
                    par_nx   = filt_dat;
                    state_nx = STOP;
                end
                STOP: begin
                    state_nx = IDLE;
                    if (filt_dat && ^{shreg, par})
                        push_nx = 1'b1;
                    else
                        perr_nx = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_ports.sv
// PS/2 keyboard I/O port: scancode FIFO, status register, level irq.
// Build option PS2_RX_TIMEOUT_EN enables the stalled-frame abort.
module ps2_kbd_ports
    import ps2_pkg::*;
#(
    parameter int fifo_depth = 8,
    parameter int filter_len = 4
`ifdef PS2_RX_TIMEOUT_EN
    ,
    parameter int timeout_cycles = 50000
`endif
) (
    input  logic            clk,
    input  logic            reset,
    ps2_kbd_ports_if.slave  bus,
    input  logic            ps2_clk,
    input  logic            ps2_dat,
    output logic            irq
);

    localparam int AW = $clog2(fifo_depth);

    logic [7:0]    mem [fifo_depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nx;
    logic          acc_q, wr_q, fbit_q;
    logic [1:0]    bsel_q;
    logic          ovf, perr_st;
    logic [7:0]    rx_byte;
    logic          byte_valid, rx_perr;
    logic          empty, full, pop, flush, push_ok, ovf_set;
    logic [15:0]   rd_word;
    logic          unused_din;

    ps2_frame_rx #(
        .filter_len(filter_len)
`ifdef PS2_RX_TIMEOUT_EN
        ,
        .timeout_cycles(timeout_cycles)
`endif
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .perr      (rx_perr)
    );

    assign unused_din = ^{bus.data_m_data_in[15:9],
                          bus.data_m_data_in[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= 1'b0;
            wr_q   <= 1'b0;
            bsel_q <= '0;
            fbit_q <= 1'b0;
        end else begin
            acc_q  <= bus.cs & bus.data_m_access;
            wr_q   <= bus.data_m_wr_en;
            bsel_q <= bus.data_m_bytesel;
            fbit_q <= bus.data_m_data_in[CTRL_FLUSH];
        end
    end

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(fifo_depth));

    // Side effects of an access land in its ack cycle.
    assign pop     = acc_q & ~wr_q & bsel_q[0] & ~empty;
    assign flush   = acc_q & wr_q & bsel_q[1] & fbit_q;
    assign push_ok = byte_valid & (~full | pop) & ~flush;
    assign ovf_set = byte_valid & full & ~pop & ~flush;

    always_comb begin
        count_nx = count;
        unique case (1'b1)
            flush:           count_nx = '0;
            push_ok & ~pop:  count_nx = count + (AW+1)'(1);
            pop & ~push_ok:  count_nx = count - (AW+1)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            perr_st <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_nx;
            irq     <= (count_nx != '0);
            ovf     <= flush ? 1'b0 : (ovf | ovf_set);
            perr_st <= flush ? 1'b0 : (perr_st | rx_perr);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= rx_byte;
    end

    always_comb begin
        rd_word             = '0;
        rd_word[7:0]        = empty ? 8'h00 : mem[rd_ptr];
        rd_word[STAT_VALID] = ~empty;
        rd_word[STAT_OVF]   = ovf;
        rd_word[STAT_PERR]  = perr_st;
    end

    assign bus.data_m_ack      = acc_q;
    assign bus.data_m_data_out = (acc_q & ~wr_q) ? rd_word : 16'h0000;

endmodule

// File: tb/tb_ps2_kbd_ports.sv
// Self-checking bench for ps2_kbd_ports with a model-queue scoreboard.
module tb_ps2_kbd_ports;
    import ps2_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk;
    logic ps2_dat;
    logic irq;

    ps2_kbd_ports_if bus ();

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q[$];
    bit m_ovf;
    bit m_perr;

    always #5 clk = ~clk;

    ps2_kbd_ports #(
        .fifo_depth(DEPTH),
        .filter_len(4)
`ifdef PS2_RX_TIMEOUT_EN
        ,
        .timeout_cycles(TMO)
`endif
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .irq    (irq)
    );

    function automatic logic [15:0] exp_word();
        logic [7:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 8'h00;
        return {5'b0, m_perr, m_ovf, (m_q.size() != 0), head};
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (bad)
            m_perr = 1'b1;
        else if (m_q.size() >= DEPTH)
            m_ovf = 1'b1;
        else
            m_q.push_back(b);
    endtask

    task automatic drive_bit(input logic v, input bit glitch);
        @(negedge clk);
        ps2_dat = v;
        repeat (4) @(negedge clk);
        if (glitch) begin
            ps2_clk = 1'b0;
            @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic sync_read_at_stop();
        logic [15:0] exp;
        bit found;
        @(negedge clk);
        ps2_dat = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (dut.u_rx.strobe === 1'b1)
                found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stop_strobe: got none expected strobe");
        end else begin
            exp = exp_word();
            bus.cs = 1'b1;
            bus.data_m_access = 1'b1;
            bus.data_m_wr_en = 1'b0;
            bus.data_m_bytesel = 2'b11;
            @(negedge clk);
            bus.cs = 1'b0;
            bus.data_m_access = 1'b0;
            checks++;
            if (bus.data_m_ack !== 1'b1 || bus.data_m_data_out !== exp) begin
                errors++;
                $display("FAIL race_read: got %h/%b expected %h/1",
                         bus.data_m_data_out, bus.data_m_ack, exp);
            end
            if (m_q.size() != 0)
                void'(m_q.pop_front());
        end
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad,
                              input int gbit, input bit pop_sync);
        logic [10:0] bits;
        logic p;
        p = (~^b) ^ bad;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < 10; i++)
            drive_bit(bits[i], i == gbit);
        if (pop_sync)
            sync_read_at_stop();
        else
            drive_bit(bits[10], 1'b0);
        model_frame(b, bad);
        repeat (5) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] bsel, input string name);
        logic [15:0] exp;
        exp = exp_word();
        @(negedge clk);
        bus.cs = 1'b1;
        bus.data_m_access = 1'b1;
        bus.data_m_wr_en = 1'b0;
        bus.data_m_bytesel = bsel;
        @(negedge clk);
        bus.cs = 1'b0;
        bus.data_m_access = 1'b0;
        checks++;
        if (bus.data_m_ack !== 1'b1 || bus.data_m_data_out !== exp) begin
            errors++;
            $display("FAIL %s: got %h/%b expected %h/1", name,
                     bus.data_m_data_out, bus.data_m_ack, exp);
        end
        if (bsel[0] && m_q.size() != 0)
            void'(m_q.pop_front());
        @(negedge clk);
        checks++;
        if (bus.data_m_ack !== 1'b0 || bus.data_m_data_out !== 16'h0) begin
            errors++;
            $display("FAIL %s_ack_len: got %h/%b expected 0000/0", name,
                     bus.data_m_data_out, bus.data_m_ack);
        end
    endtask

    task automatic bus_write(input logic [1:0] bsel, input logic [15:0] d);
        @(negedge clk);
        bus.cs = 1'b1;
        bus.data_m_access = 1'b1;
        bus.data_m_wr_en = 1'b1;
        bus.data_m_bytesel = bsel;
        bus.data_m_data_in = d;
        @(negedge clk);
        bus.cs = 1'b0;
        bus.data_m_access = 1'b0;
        bus.data_m_wr_en = 1'b0;
        checks++;
        if (bus.data_m_ack !== 1'b1) begin
            errors++;
            $display("FAIL write_ack: got %b expected 1", bus.data_m_ack);
        end
        if (bsel[1] && d[CTRL_FLUSH]) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_perr = 1'b0;
        end
    endtask

    task automatic check_irq(input logic exp, input string name);
        checks++;
        if (irq !== exp) begin
            errors++;
            $display("FAIL %s: got irq=%b expected %b", name, irq, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        bus.cs = 1'b0;
        bus.data_m_access = 1'b0;
        bus.data_m_wr_en = 1'b0;
        bus.data_m_bytesel = 2'b00;
        bus.data_m_data_in = 16'h0;
        m_q.delete();
        m_ovf = 1'b0;
        m_perr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.data_m_ack !== 1'b0 || bus.data_m_data_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h/%b expected 0000/0",
                     bus.data_m_data_out, bus.data_m_ack);
        end
        check_irq(1'b0, "reset_irq");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        bus_read(2'b10, "reset_status");
    endtask

    task automatic test_reset_midframe();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive_bit(1'b1, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (dut.u_rx.state !== IDLE) begin
            errors++;
            $display("FAIL midframe_state: got %0d expected IDLE",
                     dut.u_rx.state);
        end
        repeat (10) @(negedge clk);
        send_frame(8'h2B, 1'b0, -1, 1'b0);
        bus_read(2'b11, "midframe_read");
    endtask

    task automatic test_basic();
        send_frame(8'h1C, 1'b0, -1, 1'b0);
        check_irq(1'b1, "basic_irq_up");
        bus_read(2'b11, "basic_read");
        bus_read(2'b11, "basic_empty");
        check_irq(1'b0, "basic_irq_down");
    endtask

    task automatic test_parity();
        send_frame(8'h1C, 1'b1, -1, 1'b0);
        check_irq(1'b0, "perr_irq");
        bus_read(2'b10, "perr_status");
        bus_write(2'b10, 16'h0100);
        bus_read(2'b10, "perr_cleared");
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++)
            send_frame(8'(i), 1'b0, -1, 1'b0);
        check_irq(1'b1, "ovf_irq");
        for (int i = 0; i < 9; i++)
            bus_read(2'b11, "ovf_read");
        check_irq(1'b0, "ovf_irq_down");
        bus_write(2'b11, 16'h0100);
    endtask

    task automatic test_glitch();
        send_frame(8'h33, 1'b0, 3, 1'b0);
        send_frame(8'h44, 1'b0, -1, 1'b0);
        bus_read(2'b11, "glitch_first");
        bus_read(2'b11, "glitch_second");
        bus_read(2'b11, "glitch_empty");
    endtask

    task automatic test_back_to_back();
        int low_seen;
        send_frame(8'hA5, 1'b0, -1, 1'b0);
        low_seen = 0;
        fork
            send_frame(8'h3C, 1'b0, -1, 1'b1);
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (irq !== 1'b1)
                    low_seen++;
            end
        join
        checks++;
        if (low_seen != 0) begin
            errors++;
            $display("FAIL race_irq: got %0d low cycles expected 0",
                     low_seen);
        end
        checks++;
        if (dut.count !== 4'(m_q.size())) begin
            errors++;
            $display("FAIL race_count: got %0d expected %0d",
                     dut.count, m_q.size());
        end
        bus_read(2'b11, "race_next");
        check_irq(1'b0, "race_irq_down");
    endtask

`ifdef PS2_RX_TIMEOUT_EN
    task automatic test_timeout();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(1'b1, 1'b0);
        repeat (TMO + 20) @(negedge clk);
        m_perr = 1'b1;
        checks++;
        if (dut.u_rx.state !== IDLE) begin
            errors++;
            $display("FAIL tmo_state: got %0d expected IDLE",
                     dut.u_rx.state);
        end
        bus_read(2'b10, "tmo_status");
        send_frame(8'h5A, 1'b0, -1, 1'b0);
        bus_read(2'b11, "tmo_next");
        bus_write(2'b10, 16'h0100);
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_midframe();
        test_basic();
        test_parity();
        test_overflow();
        test_glitch();
        test_back_to_back();
`ifdef PS2_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ports.md
Name: ps2_kbd_ports

Overview:
- I/O-bus peripheral on the CPU data bus. Decodes alongside the UART, SPI and IRQ-controller ports; its read data and ack are OR-ed into the shared I/O return paths.
- Receives PS/2 keyboard frames, checks them, and buffers scancodes in a FIFO.
- Drives a level interrupt request that feeds one IRQController input.

Parameters:
- fifo_depth, 8, scancode FIFO entries; power of two, 2..64.
- filter_len, 4, consecutive equal samples needed to accept a new ps2_clk/ps2_dat level.
- timeout_cycles, 50000, idle-clock abort limit; used only with PS2_RX_TIMEOUT_EN (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  address decode hit for this port.
- data_m_access  in  1  bus access strobe.
- data_m_wr_en  in  1  1 = write.
- data_m_bytesel  in  2  byte lanes.
- data_m_data_in  in  16  write data from CPU.
- data_m_data_out  out  16  read data; 0 when not acking.
- data_m_ack  out  1  one-cycle access completion.
- ps2_clk  in  1  raw keyboard clock pin (asynchronous).
- ps2_dat  in  1  raw keyboard data pin (asynchronous).
- irq  out  1  high while FIFO non-empty.

Behaviour:
- Reset values: data_m_ack=0, data_m_data_out=0, irq=0, FIFO empty, overflow=0, parity_err=0, receiver IDLE.
- Reset asserted mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_dat each pass a 2-flop synchronizer, then a filter_len-sample glitch filter.
  - A falling edge of the filtered clock is the bit strobe.
- Receiver FSM, advancing only on bit strobes:
  - IDLE: strobe with dat=0 -> DATA, bit count=0. Strobe with dat=1 is ignored (false start).
  - DATA: shift dat into bit 7 of a shift register (LSB-first frame); after 8 strobes -> PARITY.
  - PARITY: latch dat -> STOP.
  - STOP: if dat=1 and data+parity has odd weight, push the byte; otherwise set sticky parity_err and drop the byte. Return to IDLE.
- Push/pop rules:
  - Push onto a full FIFO drops the byte and sets sticky overflow.
  - Push and pop in the same cycle both take effect; count is unchanged.
- Bus access:
  - Access = cs & data_m_access. data_m_ack asserts exactly one cycle after the access cycle.
  - data_m_data_out is valid only in the ack cycle and 0 otherwise, so it is safe to OR onto the shared bus.
- Read word: [7:0] head scancode (0 if empty), [8] valid (non-empty), [9] overflow, [10] parity_err, [15:11] 0.
- Read with bytesel[0]=1 and valid=1 pops the head in the ack cycle. A read with bytesel[0]=0 is status-only and does not pop.
- Write with bytesel[1]=1 and data_m_data_in[8]=1 flushes the FIFO and clears overflow and parity_err in the ack cycle. Other writes are acked and ignored.
- If a push and a flush land in the same cycle, the flush wins.
- irq = FIFO non-empty, registered; it drops the cycle after the pop that empties the FIFO.
- FIFO pointers are log2(fifo_depth) bits and wrap naturally. The count is one bit wider to distinguish full from empty.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Defined: in any non-IDLE state, a counter counts cycles since the last strobe. Reaching timeout_cycles returns the FSM to IDLE, discards the partial frame, and sets parity_err. The counter clears on every strobe.
- Undefined: no counter is built; a stalled frame waits indefinitely.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - PS2_DATA_BITS=8;
  - status bit indices STAT_VALID=8, STAT_OVF=9, STAT_PERR=10;
  - control bit CTRL_FLUSH=8.
- Sub-module ps2_frame_rx: synchronizer, glitch filter, FSM and optional timeout. Outputs byte, byte_valid pulse and perr pulse.
- The top level holds the FIFO, register interface and irq.

Test Plan:
- Send frame for 0x1C (parity bit 0) -> irq rises. Read with bytesel=2'b11 returns 0x011C; next read returns 0x0000; irq=0.
- Send 0x1C with parity bit 1 -> no push, irq stays 0. Status read returns 0x0400.
- Send 9 frames 0x01..0x09 with fifo_depth=8 -> reads return 0x0301..0x0308 (overflow set), then 0x0200.
- Single-cycle low glitch on ps2_clk during DATA -> no extra bit shifted; the next frame decodes correctly.
- Frame completes in the same cycle as a pop of the last entry -> count stays 1, irq stays 1, the new byte is read next.
- With PS2_RX_TIMEOUT_EN: stop clocking after 4 data bits for timeout_cycles+1 -> FSM IDLE, parity_err=1. A following 0x5A frame reads 0x055A.
